// File: rtl/axi_ram_cmd_arb.sv
// Two-port round-robin arbiter sharing one RAM command/read-response interface.
// Grants are held for a whole burst; read responses return via an in-order tag FIFO.
module axi_ram_cmd_arb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int TAG_FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   s0_cmd_id,
    input  logic [ADDR_WIDTH-1:0] s0_cmd_addr,
    input  logic [DATA_WIDTH-1:0] s0_cmd_wr_data,
    input  logic [STRB_WIDTH-1:0] s0_cmd_wr_strb,
    input  logic                  s0_cmd_wr_en,
    input  logic                  s0_cmd_rd_en,
    input  logic                  s0_cmd_last,
    output logic                  s0_cmd_ready,
    output logic [ID_WIDTH-1:0]   s0_rd_resp_id,
    output logic [DATA_WIDTH-1:0] s0_rd_resp_data,
    output logic                  s0_rd_resp_last,
    output logic                  s0_rd_resp_valid,
    input  logic                  s0_rd_resp_ready,

    input  logic [ID_WIDTH-1:0]   s1_cmd_id,
    input  logic [ADDR_WIDTH-1:0] s1_cmd_addr,
    input  logic [DATA_WIDTH-1:0] s1_cmd_wr_data,
    input  logic [STRB_WIDTH-1:0] s1_cmd_wr_strb,
    input  logic                  s1_cmd_wr_en,
    input  logic                  s1_cmd_rd_en,
    input  logic                  s1_cmd_last,
    output logic                  s1_cmd_ready,
    output logic [ID_WIDTH-1:0]   s1_rd_resp_id,
    output logic [DATA_WIDTH-1:0] s1_rd_resp_data,
    output logic                  s1_rd_resp_last,
    output logic                  s1_rd_resp_valid,
    input  logic                  s1_rd_resp_ready,

    output logic [ID_WIDTH-1:0]   m_cmd_id,
    output logic [ADDR_WIDTH-1:0] m_cmd_addr,
    output logic [DATA_WIDTH-1:0] m_cmd_wr_data,
    output logic [STRB_WIDTH-1:0] m_cmd_wr_strb,
    output logic                  m_cmd_wr_en,
    output logic                  m_cmd_rd_en,
    output logic                  m_cmd_last,
    input  logic                  m_cmd_ready,
    input  logic [ID_WIDTH-1:0]   m_rd_resp_id,
    input  logic [DATA_WIDTH-1:0] m_rd_resp_data,
    input  logic                  m_rd_resp_last,
    input  logic                  m_rd_resp_valid,
    output logic                  m_rd_resp_ready
);

    localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(TAG_FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic                      locked;
    logic                      owner;
    logic                      last_grant;
    logic [TAG_FIFO_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W:0]            count;

    logic tag_full, tag_empty, head;
    logic rd0, rd1, req0, req1;
    logic sel, granted;
    logic accept, push, pop;

    assign tag_full  = (count == CNT_FULL);
    assign tag_empty = (count == '0);
    assign head      = tag_mem[rd_ptr];

    // Reads are masked on a full FIFO regardless of a same-cycle pop.
    assign rd0  = s0_cmd_rd_en && !tag_full;
    assign rd1  = s1_cmd_rd_en && !tag_full;
    assign req0 = s0_cmd_wr_en || rd0;
    assign req1 = s1_cmd_wr_en || rd1;

    always_comb begin
        sel     = owner;
        granted = 1'b0;
        if (locked) begin
            sel     = owner;
            granted = owner ? req1 : req0;
        end else if (req0 && req1) begin
            sel     = !last_grant;
            granted = 1'b1;
        end else if (req0) begin
            sel     = 1'b0;
            granted = 1'b1;
        end else if (req1) begin
            sel     = 1'b1;
            granted = 1'b1;
        end
    end

    assign m_cmd_id      = sel ? s1_cmd_id      : s0_cmd_id;
    assign m_cmd_addr    = sel ? s1_cmd_addr    : s0_cmd_addr;
    assign m_cmd_wr_data = sel ? s1_cmd_wr_data : s0_cmd_wr_data;
    assign m_cmd_wr_strb = sel ? s1_cmd_wr_strb : s0_cmd_wr_strb;
    assign m_cmd_last    = sel ? s1_cmd_last    : s0_cmd_last;
    assign m_cmd_wr_en   = granted && (sel ? s1_cmd_wr_en : s0_cmd_wr_en);
    assign m_cmd_rd_en   = granted && (sel ? rd1 : rd0);

    assign s0_cmd_ready = m_cmd_ready && granted && !sel;
    assign s1_cmd_ready = m_cmd_ready && granted && sel;

    assign m_rd_resp_ready  = !tag_empty && (head ? s1_rd_resp_ready : s0_rd_resp_ready);
    assign s0_rd_resp_valid = m_rd_resp_valid && !tag_empty && !head;
    assign s1_rd_resp_valid = m_rd_resp_valid && !tag_empty && head;

    assign s0_rd_resp_id   = m_rd_resp_id;
    assign s0_rd_resp_data = m_rd_resp_data;
    assign s0_rd_resp_last = m_rd_resp_last;
    assign s1_rd_resp_id   = m_rd_resp_id;
    assign s1_rd_resp_data = m_rd_resp_data;
    assign s1_rd_resp_last = m_rd_resp_last;

    assign accept = m_cmd_ready && (m_cmd_wr_en || m_cmd_rd_en);
    assign push   = accept && m_cmd_rd_en;
    assign pop    = m_rd_resp_valid && m_rd_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked     <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            tag_mem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (accept) begin
                last_grant <= sel;
                locked     <= !m_cmd_last;
                owner      <= sel;
            end
            if (push) begin
                tag_mem[wr_ptr] <= sel;
                wr_ptr          <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_cmd_arb.sv
// Self-checking bench for axi_ram_cmd_arb: directed scenarios, then random traffic
// against a queue-based reference model of grants, burst locks and response routing.
module tb_axi_ram_cmd_arb;

    localparam int DW = 32, AW = 16, SW = 4, IW = 8, DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IW-1:0] s0_cmd_id, s1_cmd_id, m_cmd_id, m_rd_resp_id;
    logic [AW-1:0] s0_cmd_addr, s1_cmd_addr, m_cmd_addr;
    logic [DW-1:0] s0_cmd_wr_data, s1_cmd_wr_data, m_cmd_wr_data, m_rd_resp_data;
    logic [SW-1:0] s0_cmd_wr_strb, s1_cmd_wr_strb, m_cmd_wr_strb;
    logic s0_cmd_wr_en, s0_cmd_rd_en, s0_cmd_last, s0_cmd_ready;
    logic s1_cmd_wr_en, s1_cmd_rd_en, s1_cmd_last, s1_cmd_ready;
    logic [IW-1:0] s0_rd_resp_id, s1_rd_resp_id;
    logic [DW-1:0] s0_rd_resp_data, s1_rd_resp_data;
    logic s0_rd_resp_last, s0_rd_resp_valid, s0_rd_resp_ready;
    logic s1_rd_resp_last, s1_rd_resp_valid, s1_rd_resp_ready;
    logic m_cmd_wr_en, m_cmd_rd_en, m_cmd_last, m_cmd_ready;
    logic m_rd_resp_last, m_rd_resp_valid, m_rd_resp_ready;

    axi_ram_cmd_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
        .ID_WIDTH(IW), .TAG_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_cmd_id(s0_cmd_id), .s0_cmd_addr(s0_cmd_addr), .s0_cmd_wr_data(s0_cmd_wr_data),
        .s0_cmd_wr_strb(s0_cmd_wr_strb), .s0_cmd_wr_en(s0_cmd_wr_en), .s0_cmd_rd_en(s0_cmd_rd_en),
        .s0_cmd_last(s0_cmd_last), .s0_cmd_ready(s0_cmd_ready),
        .s0_rd_resp_id(s0_rd_resp_id), .s0_rd_resp_data(s0_rd_resp_data),
        .s0_rd_resp_last(s0_rd_resp_last), .s0_rd_resp_valid(s0_rd_resp_valid),
        .s0_rd_resp_ready(s0_rd_resp_ready),
        .s1_cmd_id(s1_cmd_id), .s1_cmd_addr(s1_cmd_addr), .s1_cmd_wr_data(s1_cmd_wr_data),
        .s1_cmd_wr_strb(s1_cmd_wr_strb), .s1_cmd_wr_en(s1_cmd_wr_en), .s1_cmd_rd_en(s1_cmd_rd_en),
        .s1_cmd_last(s1_cmd_last), .s1_cmd_ready(s1_cmd_ready),
        .s1_rd_resp_id(s1_rd_resp_id), .s1_rd_resp_data(s1_rd_resp_data),
        .s1_rd_resp_last(s1_rd_resp_last), .s1_rd_resp_valid(s1_rd_resp_valid),
        .s1_rd_resp_ready(s1_rd_resp_ready),
        .m_cmd_id(m_cmd_id), .m_cmd_addr(m_cmd_addr), .m_cmd_wr_data(m_cmd_wr_data),
        .m_cmd_wr_strb(m_cmd_wr_strb), .m_cmd_wr_en(m_cmd_wr_en), .m_cmd_rd_en(m_cmd_rd_en),
        .m_cmd_last(m_cmd_last), .m_cmd_ready(m_cmd_ready),
        .m_rd_resp_id(m_rd_resp_id), .m_rd_resp_data(m_rd_resp_data),
        .m_rd_resp_last(m_rd_resp_last), .m_rd_resp_valid(m_rd_resp_valid),
        .m_rd_resp_ready(m_rd_resp_ready)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: -1 means no burst in progress; rr_next is the tie winner.
    int lock_owner = -1;
    int rr_next = 0;
    bit tagq[$];

    int   obs_grant;
    logic obs_mr, obs_v0, obs_v1, obs_last0;
    int   exp_g;
    bit   exp_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lock_owner = -1;
        rr_next = 0;
        tagq.delete();
    endtask

    task automatic drv(input int p, input bit wr, input bit rd, input bit last, input logic [AW-1:0] addr);
        if (p == 0) begin
            s0_cmd_wr_en = wr; s0_cmd_rd_en = rd; s0_cmd_last = last; s0_cmd_addr = addr;
            s0_cmd_id = IW'($urandom); s0_cmd_wr_data = $urandom; s0_cmd_wr_strb = SW'($urandom);
        end else begin
            s1_cmd_wr_en = wr; s1_cmd_rd_en = rd; s1_cmd_last = last; s1_cmd_addr = addr;
            s1_cmd_id = IW'($urandom); s1_cmd_wr_data = $urandom; s1_cmd_wr_strb = SW'($urandom);
        end
    endtask

    task automatic idle_cmds();
        drv(0, 1'b0, 1'b0, 1'b0, '0);
        drv(1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic resp(input bit v, input logic [DW-1:0] d, input bit last, input bit r0, input bit r1);
        m_rd_resp_valid = v; m_rd_resp_data = d; m_rd_resp_last = last;
        m_rd_resp_id = IW'($urandom);
        s0_rd_resp_ready = r0; s1_rd_resp_ready = r1;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic step();
        bit full, r0, r1, ewr, erd, emr, ev0, ev1, elast, pop;
        int g;
        #1;
        full = (tagq.size() >= DEPTH);
        r0 = s0_cmd_wr_en || (s0_cmd_rd_en && !full);
        r1 = s1_cmd_wr_en || (s1_cmd_rd_en && !full);
        if (lock_owner >= 0) g = ((lock_owner == 0) ? r0 : r1) ? lock_owner : -1;
        else if (r0 && r1)   g = rr_next;
        else if (r0)         g = 0;
        else if (r1)         g = 1;
        else                 g = -1;
        ewr = (g == 0) ? s0_cmd_wr_en : (g == 1) ? s1_cmd_wr_en : 1'b0;
        erd = (g == 0) ? (s0_cmd_rd_en && !full) : (g == 1) ? (s1_cmd_rd_en && !full) : 1'b0;
        elast = (g == 1) ? s1_cmd_last : s0_cmd_last;
        chk("m_cmd_wr_en", m_cmd_wr_en, ewr);
        chk("m_cmd_rd_en", m_cmd_rd_en, erd);
        chk("s0_cmd_ready", s0_cmd_ready, m_cmd_ready && g == 0);
        chk("s1_cmd_ready", s1_cmd_ready, m_cmd_ready && g == 1);
        if (g >= 0) begin
            chk("m_cmd_addr", m_cmd_addr, (g == 1) ? s1_cmd_addr : s0_cmd_addr);
            chk("m_cmd_id", m_cmd_id, (g == 1) ? s1_cmd_id : s0_cmd_id);
            chk("m_cmd_wr_data", m_cmd_wr_data, (g == 1) ? s1_cmd_wr_data : s0_cmd_wr_data);
            chk("m_cmd_wr_strb", m_cmd_wr_strb, (g == 1) ? s1_cmd_wr_strb : s0_cmd_wr_strb);
            chk("m_cmd_last", m_cmd_last, elast);
        end
        if (tagq.size() > 0) begin
            emr = tagq[0] ? s1_rd_resp_ready : s0_rd_resp_ready;
            ev0 = m_rd_resp_valid && !tagq[0];
            ev1 = m_rd_resp_valid && tagq[0];
        end else begin
            emr = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
        end
        chk("m_rd_resp_ready", m_rd_resp_ready, emr);
        chk("s0_rd_resp_valid", s0_rd_resp_valid, ev0);
        chk("s1_rd_resp_valid", s1_rd_resp_valid, ev1);
        if (m_rd_resp_valid) begin
            chk("s0_rd_resp_data", s0_rd_resp_data, m_rd_resp_data);
            chk("s1_rd_resp_data", s1_rd_resp_data, m_rd_resp_data);
            chk("s0_rd_resp_id", s0_rd_resp_id, m_rd_resp_id);
            chk("s1_rd_resp_last", s1_rd_resp_last, m_rd_resp_last);
        end
        obs_grant = s0_cmd_ready ? 0 : (s1_cmd_ready ? 1 : 3);
        obs_mr = m_rd_resp_ready; obs_v0 = s0_rd_resp_valid; obs_v1 = s1_rd_resp_valid;
        obs_last0 = s0_rd_resp_last;
        exp_g = g;
        exp_acc = m_cmd_ready && g >= 0 && (ewr || erd);
        pop = m_rd_resp_valid && emr;
        @(posedge clk);
        if (pop) void'(tagq.pop_front());
        if (exp_acc) begin
            rr_next = (g == 0) ? 1 : 0;
            lock_owner = elast ? -1 : g;
            if (erd) tagq.push_back(g == 1);
        end
        @(negedge clk);
    endtask

    task automatic stepg(input string tag, input int eg);
        step();
        chk(tag, obs_grant, eg);
    endtask

    int rem[2];
    bit isrd[2];

    initial begin
        rst = 1'b1;
        idle_cmds();
        resp(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        m_cmd_ready = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_m_rd_resp_ready", m_rd_resp_ready, 1'b0);
        chk("rst_s0_rd_resp_valid", s0_rd_resp_valid, 1'b0);
        chk("rst_s1_rd_resp_valid", s1_rd_resp_valid, 1'b0);
        chk("rst_en", {m_cmd_wr_en, m_cmd_rd_en}, 2'b00);
        chk("rst_ready", {s0_cmd_ready, s1_cmd_ready}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Tie: continuous single-beat writes alternate, port 0 first.
        for (int i = 0; i < 6; i++) begin
            drv(0, 1'b1, 1'b0, 1'b1, AW'(16'h100 + i));
            drv(1, 1'b1, 1'b0, 1'b1, AW'(16'h200 + i));
            stepg("tie_rr", i % 2);
        end
        idle_cmds();

        drv(0, 1'b1, 1'b0, 1'b1, 16'h0010);
        step();
        chk("single_wr_grant", obs_grant, 0);
        chk("single_wr_addr_seen", exp_g, 0);
        idle_cmds();

        // Burst lock: 4-beat s0 write, s1 waiting from beat 1.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drv(0, 1'b1, 1'b0, i == 3, AW'(16'h300 + i)); else drv(0, 1'b0, 1'b0, 1'b0, '0);
            drv(1, i >= 1, 1'b0, 1'b1, 16'h0400);
            stepg("burst_lock", (i < 4) ? 0 : 1);
        end
        // Burst with an owner idle cycle in the middle: no grant that cycle.
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) drv(0, 1'b0, 1'b0, 1'b0, '0);
            else drv(0, 1'b1, 1'b0, i == 4, AW'(16'h500 + i));
            drv(1, 1'b1, 1'b0, 1'b1, 16'h0600);
            stepg("burst_gap", (i == 2) ? 3 : (i == 5) ? 1 : 0);
        end
        idle_cmds();

        // Read routing: s0 2-beat read, s1 1-beat read, three responses.
        drv(0, 1'b0, 1'b1, 1'b0, 16'h0700); stepg("rd_s0_b1", 0);
        drv(0, 1'b0, 1'b1, 1'b1, 16'h0701); stepg("rd_s0_b2", 0);
        drv(0, 1'b0, 1'b0, 1'b0, '0);
        drv(1, 1'b0, 1'b1, 1'b1, 16'h0800); stepg("rd_s1_b1", 1);
        idle_cmds();
        for (int i = 0; i < 3; i++) begin
            resp(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1);
            step();
            chk("stall_mready", obs_mr, 1'b0);
            chk("stall_v0", obs_v0, 1'b1);
        end
        resp(1'b1, 32'hA1, 1'b0, 1'b1, 1'b1); step();
        chk("beat1_v0", obs_v0, 1'b1); chk("beat1_mready", obs_mr, 1'b1);
        resp(1'b1, 32'hA2, 1'b1, 1'b1, 1'b1); step();
        chk("beat2_v0", obs_v0, 1'b1); chk("beat2_last", obs_last0, 1'b1);
        resp(1'b1, 32'hA3, 1'b1, 1'b1, 1'b1); step();
        chk("beat3_v1", obs_v1, 1'b1); chk("beat3_v0", obs_v0, 1'b0);
        // A response with nothing outstanding is held and never routed.
        resp(1'b1, 32'hEE, 1'b0, 1'b1, 1'b1); step();
        chk("empty_mready", obs_mr, 1'b0);
        chk("empty_valid", {obs_v0, obs_v1}, 2'b00);
        resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Tag FIFO full at DEPTH outstanding reads.
        for (int i = 0; i < DEPTH; i++) begin
            drv(0, 1'b0, 1'b1, 1'b1, AW'(16'h900 + i));
            stepg("fill_rd", 0);
        end
        drv(0, 1'b0, 1'b1, 1'b1, 16'h0A00); stepg("full_blocked", 3);
        drv(0, 1'b0, 1'b1, 1'b1, 16'h0A00);
        drv(1, 1'b1, 1'b0, 1'b1, 16'h0B00); stepg("full_wr_proceeds", 1);
        drv(1, 1'b0, 1'b0, 1'b0, '0);
        drv(0, 1'b0, 1'b1, 1'b1, 16'h0A00);
        resp(1'b1, 32'hB0, 1'b1, 1'b1, 1'b1);
        step();
        chk("full_pop_same_cycle", obs_grant, 3);
        chk("full_pop_mready", obs_mr, 1'b1);
        resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drv(0, 1'b0, 1'b1, 1'b1, 16'h0A00); stepg("full_unblocked", 0);
        idle_cmds();
        for (int i = 0; i < DEPTH; i++) begin
            resp(1'b1, DW'(32'hC0 + i), 1'b1, 1'b1, 1'b1);
            step();
        end
        resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of an s1 burst with a tag outstanding.
        drv(0, 1'b0, 1'b1, 1'b1, 16'h0C00); stepg("pre_rst_rd", 0);
        drv(0, 1'b0, 1'b0, 1'b0, '0);
        drv(1, 1'b1, 1'b0, 1'b0, 16'h0D00); stepg("pre_rst_b1", 1);
        drv(0, 1'b1, 1'b0, 1'b1, 16'h0E00);
        drv(1, 1'b1, 1'b0, 1'b0, 16'h0D01); stepg("pre_rst_b2", 1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drv(0, 1'b1, 1'b0, 1'b1, 16'h0E00);
        drv(1, 1'b1, 1'b0, 1'b0, 16'h0D02);
        resp(1'b1, 32'hDD, 1'b0, 1'b1, 1'b1);
        step();
        chk("post_rst_grant", obs_grant, 0);
        chk("post_rst_fifo_empty", obs_mr, 1'b0);
        idle_cmds();
        resp(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Random bursts, backpressure and responses against the model.
        rem[0] = 0; rem[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                bit present;
                if (rem[p] == 0 && $urandom_range(0, 2) == 0) begin
                    rem[p] = $urandom_range(1, 4);
                    isrd[p] = $urandom_range(0, 1) == 1;
                end
                present = rem[p] > 0 && $urandom_range(0, 3) != 0;
                drv(p, present && !isrd[p], present && isrd[p], rem[p] == 1, AW'($urandom));
            end
            m_cmd_ready = $urandom_range(0, 3) != 0;
            resp($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
            if (exp_acc) rem[exp_g]--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_ram_cmd_arb.md
# axi_ram_cmd_arb

Two-port arbiter that shares one RAM command/read-response interface between two AXI RAM front ends, each producing the merged read/write command stream (`ram_cmd_*`) and consuming the read-response stream (`ram_rd_resp_*`). Grants round-robin between the two ports and holds a grant for the full length of a burst. Read-response beats are returned to the originating port through an in-order routing-tag FIFO. The block sits between two AXI RAM read/write interfaces and a single RAM back end, so two AXI masters can share one memory.

## Interface
- `DATA_WIDTH`, default 32: data bus width.
- `ADDR_WIDTH`, default 16: address width.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: write strobe width.
- `ID_WIDTH`, default 8: ID width, passed through unchanged.
- `TAG_FIFO_DEPTH`, default 16: maximum outstanding read beats; must be a power of two, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `s0_cmd_id`/`s1_cmd_id` in `ID_WIDTH`: command ID per port.
- `s0_cmd_addr`/`s1_cmd_addr` in `ADDR_WIDTH`: command word address.
- `s0_cmd_wr_data`/`s1_…` in `DATA_WIDTH`: write data.
- `s0_cmd_wr_strb`/`s1_…` in `STRB_WIDTH`: write strobes.
- `s0_cmd_wr_en`/`s1_…` in 1: write beat request.
- `s0_cmd_rd_en`/`s1_…` in 1: read beat request. Never asserted together with `wr_en` on the same port.
- `s0_cmd_last`/`s1_…` in 1: final beat of the burst.
- `s0_cmd_ready`/`s1_…` out 1: beat accepted.
- `s0_rd_resp_id`/`s1_…` out `ID_WIDTH`: response ID.
- `s0_rd_resp_data`/`s1_…` out `DATA_WIDTH`: response data.
- `s0_rd_resp_last`/`s1_…` out 1: response last.
- `s0_rd_resp_valid`/`s1_…` out 1: response valid.
- `s0_rd_resp_ready`/`s1_…` in 1: response ready.
- `m_cmd_id`, `m_cmd_addr`, `m_cmd_wr_data`, `m_cmd_wr_strb`, `m_cmd_last` out (widths as above): selected command.
- `m_cmd_wr_en`, `m_cmd_rd_en` out 1: selected command request.
- `m_cmd_ready` in 1: RAM accepts beat.
- `m_rd_resp_id`, `m_rd_resp_data`, `m_rd_resp_last` in (widths as above): RAM read response.
- `m_rd_resp_valid` in 1, `m_rd_resp_ready` out 1: RAM read response handshake.

## Operation
- **Port request.** Port p requests when `wr_en_p || (rd_en_p && !tag_full)`. A read is masked while the tag FIFO is full, even if a response pop occurs in the same cycle; writes are never masked.
- **State.**
  - `locked` (1b) and `owner` (1b) hold the burst lock.
  - `last_grant` (1b) holds the round-robin pointer.
  - The tag FIFO holds 1-bit entries, `TAG_FIFO_DEPTH` deep.
- **Arbitration (combinational, `sel`).**
  - If `locked`: `sel = owner`.
  - Otherwise, if only one port requests, select it.
  - If both request, select `!last_grant`.
  - If neither requests, there is no grant.
- **Muxing.**
  - All `m_cmd_*` data fields follow `sel`.
  - `m_cmd_wr_en`/`m_cmd_rd_en` equal the selected port's masked request bits; both are 0 when there is no grant.
  - `sN_cmd_ready = m_cmd_ready && granted && (sel==N)`.
- **On an accepted beat** (`m_cmd_ready && (m_cmd_wr_en || m_cmd_rd_en)`):
  - `last_grant <= sel`.
  - `locked <= !m_cmd_last`, `owner <= sel`.
  - If it is a read, push `sel` into the tag FIFO.
- **While locked with the owner idle:** no grant is issued. The other port waits, because the burst is never split.
- **Response routing.**
  - `head` is the FIFO output.
  - `s{head}_rd_resp_valid = m_rd_resp_valid && !tag_empty`; the other port's valid is 0.
  - `m_rd_resp_ready = s{head}_rd_resp_ready && !tag_empty`.
  - The FIFO pops on `m_rd_resp_valid && m_rd_resp_ready`.
  - Response data, ID and last fan out to both ports unchanged.
- **Response on empty FIFO:** it is held (ready 0) and never routed; this is a protocol error, checked by the bench assertion.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. Pointers wrap modulo `TAG_FIFO_DEPTH`; count is `$clog2(DEPTH)+1` bits.

## Timing
- Command path is combinational (zero latency): request to `m_cmd_*` and `m_cmd_ready` to `sN_cmd_ready` in the same cycle.
- The response path is combinational apart from the FIFO state.
- Lock, pointer and FIFO updates take effect on the next rising `clk` edge.
- The loser of a tie gets the next grant after the winner's last beat, provided it is still requesting.
- **Reset (async, `rst`=1):**
  - `locked`=0, `owner`=0, `last_grant`=1 (port 0 wins the first tie).
  - FIFO empty, with pointers and count 0.
  - Consequently `m_rd_resp_ready`=0, both `sN_rd_resp_valid`=0, and with idle inputs all `*_en`/`*_ready` outputs are 0.
- **Reset mid-burst:** the lock is dropped and outstanding tags are discarded. Upstream must be reset together with this block.

## Test plan
- **Single write:** s0 wr_en, addr 0x10, last=1, `m_cmd_ready`=1 → `m_cmd_wr_en`=1, addr 0x10, `s0_cmd_ready`=1 the same cycle; `s1_cmd_ready`=0.
- **Tie round-robin:** both ports issue continuous single-beat writes → grants go 0,1,0,1…; after reset the first grant is port 0.
- **Burst lock:** s0 issues a 4-beat write while s1 requests from cycle 1 → four consecutive s0 beats, then s1 is granted. With an s0 idle cycle mid-burst, no grant is issued that cycle.
- **Read routing:** s0 issues a 2-beat read, then s1 a 1-beat read; RAM returns 3 beats → beats 1–2 arrive on s0 with last on beat 2, beat 3 on s1. Stalling `s0_rd_resp_ready` for 3 cycles holds `m_rd_resp_ready`=0.
- **Tag full:** with DEPTH=4, issue 4 unanswered read beats → the 5th read is blocked (`rd_en` masked) while a concurrent s1 write proceeds. One response pop unblocks the read on the next cycle.
- **Reset mid-burst:** assert `rst` after 2 of 4 s1 beats → on release, s0 is granted immediately and the FIFO is empty.
